// File: rtl/c16_pkg.sv
// rtl/c16_pkg.sv - shared c16 core types: requester ids, read-pending record, bus widths
package c16_pkg;

    localparam int C16_AW = 16;
    localparam int C16_DW = 16;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } rd_pend_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - data-memory port bundle: core and loader requesters plus RAM port B
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt;
    logic          ldr_rvalid;
    logic [DW-1:0] ldr_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata, core_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_addr, mem_wdata, mem_wren,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata, core_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_addr, mem_wdata, mem_wren,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_pick.sv
// rtl/dmem_pick.sv - combinational winner select; C16_DMEM_ARB_RR_EN selects round-robin over core-first
module dmem_pick
    import c16_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       core_req,
    input  logic       ldr_req,
`ifdef C16_DMEM_ARB_RR_EN
    input  req_id_t    last_win,
`else
    input  logic [3:0] starve_cnt,
`endif
    output logic       core_win,
    output logic       ldr_win
);

    always_comb begin
        core_win = 1'b0;
        ldr_win  = 1'b0;
        if (core_req && ldr_req) begin
`ifdef C16_DMEM_ARB_RR_EN
            if (last_win == REQ_LOADER) core_win = 1'b1;
            else                        ldr_win  = 1'b1;
`else
            // A starved loader jumps ahead of the core for one grant
            if (starve_cnt == 4'(STARVE_LIMIT)) ldr_win  = 1'b1;
            else                                core_win = 1'b1;
`endif
        end else begin
            core_win = core_req;
            ldr_win  = ldr_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares RAM port B between core load/store and loader; C16_DMEM_ARB_RR_EN enables round-robin
module dmem_arbiter
    import c16_pkg::*;
#(
    parameter int AW           = C16_AW,
    parameter int DW           = C16_DW,
    parameter int STARVE_LIMIT = 3
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic     core_win;
    logic     ldr_win;
    rd_pend_t rd_pend;

`ifdef C16_DMEM_ARB_RR_EN
    req_id_t last_win;

    always_ff @(posedge clk) begin
        if (rst)               last_win <= REQ_LOADER;
        else if (bus.core_gnt) last_win <= REQ_CORE;
        else if (bus.ldr_gnt)  last_win <= REQ_LOADER;
    end
`else
    logic [3:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst || !bus.ldr_req || bus.ldr_gnt)
            starve_cnt <= 4'd0;
        else if (starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
    end
`endif

    dmem_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .core_req   (bus.core_req),
        .ldr_req    (bus.ldr_req),
`ifdef C16_DMEM_ARB_RR_EN
        .last_win   (last_win),
`else
        .starve_cnt (starve_cnt),
`endif
        .core_win   (core_win),
        .ldr_win    (ldr_win)
    );

    // Reset overrides any request in the same cycle
    assign bus.core_gnt   = core_win & ~rst;
    assign bus.ldr_gnt    = ldr_win & ~rst;
    assign bus.core_stall = bus.core_req & ~bus.core_gnt;

    always_comb begin
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = {DW{1'b0}};
        bus.mem_wren  = 1'b0;
        if (bus.core_gnt) begin
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_wren  = bus.core_we;
        end else if (bus.ldr_gnt) begin
            bus.mem_addr  = bus.ldr_addr;
            bus.mem_wdata = bus.ldr_wdata;
            bus.mem_wren  = bus.ldr_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend.valid <= 1'b0;
            rd_pend.owner <= REQ_CORE;
        end else begin
            rd_pend.valid <= (bus.core_gnt & ~bus.core_we) | (bus.ldr_gnt & ~bus.ldr_we);
            rd_pend.owner <= bus.ldr_gnt ? REQ_LOADER : REQ_CORE;
        end
    end

    // A return in flight when reset hits is dropped, not delivered
    assign bus.core_rvalid = rd_pend.valid & (rd_pend.owner == REQ_CORE) & ~rst;
    assign bus.ldr_rvalid  = rd_pend.valid & (rd_pend.owner == REQ_LOADER) & ~rst;
    assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : {DW{1'b0}};
    assign bus.ldr_rdata   = bus.ldr_rvalid ? bus.mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter against a registered RAM model
module tb_dmem_arbiter;

    localparam int LIMIT = 3;

    typedef struct packed {
        logic        owner_ldr;
        logic [15:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic rst;
    logic ram_fill;
    logic [15:0] ram [0:255];

    int n_vec = 0;
    int n_err = 0;

    ret_t sb[$];
    int   m_cnt;
    logic m_last_ldr;

    logic        obs_cg, obs_lg, obs_stall, obs_wren, obs_crv, obs_lrv;
    logic [15:0] obs_crd;
    logic        exp_cg_q, exp_lg_q;
    int          wren_cnt;

    dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

    dmem_arbiter #(
        .AW           (16),
        .DW           (16),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'(i) * 16'h0101 ^ 16'h5A5A;
        end else if (bus.mem_wren) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        ecg, elg, ecrv, elrv, ewe;
        logic [15:0] eaddr, ewd, ecd, eld;
        ret_t        r;
        @(negedge clk);
        ecg = 1'b0;
        elg = 1'b0;
        if (!rst) begin
`ifdef C16_DMEM_ARB_RR_EN
            if (bus.core_req && bus.ldr_req) begin
                ecg = m_last_ldr;
                elg = !m_last_ldr;
            end else begin
                ecg = bus.core_req;
                elg = bus.ldr_req;
            end
`else
            elg = bus.ldr_req && (!bus.core_req || m_cnt == LIMIT);
            ecg = bus.core_req && !elg;
`endif
        end
        eaddr = ecg ? bus.core_addr  : elg ? bus.ldr_addr  : 16'h0;
        ewd   = ecg ? bus.core_wdata : elg ? bus.ldr_wdata : 16'h0;
        ewe   = ecg ? bus.core_we    : elg ? bus.ldr_we    : 1'b0;
        check_eq("core_gnt", 32'(bus.core_gnt), 32'(ecg));
        check_eq("ldr_gnt", 32'(bus.ldr_gnt), 32'(elg));
        check_eq("core_stall", 32'(bus.core_stall), 32'(bus.core_req & ~ecg));
        check_eq("mem_wren", 32'(bus.mem_wren), 32'(ewe));
        check_eq("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
        check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(ewd));

        ecrv = 1'b0; elrv = 1'b0; ecd = 16'h0; eld = 16'h0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            if (!rst) begin
                if (r.owner_ldr) begin elrv = 1'b1; eld = r.data; end
                else             begin ecrv = 1'b1; ecd = r.data; end
            end
        end
        check_eq("core_rvalid", 32'(bus.core_rvalid), 32'(ecrv));
        check_eq("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(elrv));
        check_eq("core_rdata", 32'(bus.core_rdata), 32'(ecd));
        check_eq("ldr_rdata", 32'(bus.ldr_rdata), 32'(eld));

        obs_cg = bus.core_gnt; obs_lg = bus.ldr_gnt; obs_stall = bus.core_stall;
        obs_wren = bus.mem_wren; obs_crv = bus.core_rvalid; obs_crd = bus.core_rdata;
        obs_lrv = bus.ldr_rvalid;
        if (bus.mem_wren) wren_cnt++;
        exp_cg_q = ecg; exp_lg_q = elg;

        if (ecg && !bus.core_we) sb.push_back({1'b0, ram[bus.core_addr[7:0]]});
        if (elg && !bus.ldr_we)  sb.push_back({1'b1, ram[bus.ldr_addr[7:0]]});

        if (rst) begin
            m_cnt = 0;
            m_last_ldr = 1'b1;
        end else begin
            if (ecg)      m_last_ldr = 1'b0;
            else if (elg) m_last_ldr = 1'b1;
            if (!bus.ldr_req || elg) m_cnt = 0;
            else if (m_cnt < LIMIT)  m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic core_set(logic req, logic we, logic [15:0] addr, logic [15:0] wd);
        bus.core_req = req; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wd;
    endtask

    task automatic ldr_set(logic req, logic we, logic [15:0] addr, logic [15:0] wd);
        bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wd;
    endtask

    task automatic do_reset();
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        ldr_set(1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        m_cnt = 0;
        m_last_ldr = 1'b1;
        wren_cnt = 0;
        ram_fill = 1'b1;
        rst = 1'b1;
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        ldr_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        ram_fill = 1'b0;
        step();
        check_eq("rst_core_gnt", 32'(obs_cg), 32'd0);
        check_eq("rst_wren", 32'(obs_wren), 32'd0);
        rst = 1'b0;

        // Preload 0xBEEF at 0x10 through the loader
        ldr_set(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step();
        do_reset();

        // Core-only read
        core_set(1'b1, 1'b0, 16'h0010, 16'h0);
        step();
        check_eq("core_only_gnt", 32'(obs_cg), 32'd1);
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check_eq("core_only_rvalid", 32'(obs_crv), 32'd1);
        check_eq("core_only_rdata", 32'(obs_crd), 32'hBEEF);
        check_eq("core_only_ldr_rvalid", 32'(obs_lrv), 32'd0);

        // Contention, both reading every cycle
        do_reset();
        for (int i = 0; i < 12; i++) begin
            core_set(1'b1, 1'b0, 16'(8'h40 + i), 16'h0);
            ldr_set(1'b1, 1'b0, 16'(8'h80 + i), 16'h0);
            step();
`ifdef C16_DMEM_ARB_RR_EN
            check_eq("contend_ldr_gnt", 32'(obs_lg), 32'(i % 2 == 1));
            check_eq("contend_stall", 32'(obs_stall), 32'(i % 2 == 1));
`else
            check_eq("contend_ldr_gnt", 32'(obs_lg), 32'(i % 4 == 3));
            check_eq("contend_stall", 32'(obs_stall), 32'(i % 4 == 3));
`endif
        end
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        ldr_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();

        // Loader write, idle, core read of the same word
        do_reset();
        wren_cnt = 0;
        ldr_set(1'b1, 1'b1, 16'h0020, 16'h1234);
        step();
        ldr_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        core_set(1'b1, 1'b0, 16'h0020, 16'h0);
        step();
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        check_eq("wr_rd_rvalid", 32'(obs_crv), 32'd1);
        check_eq("wr_rd_rdata", 32'(obs_crd), 32'h1234);
        check_eq("wr_rd_wren_cycles", 32'(wren_cnt), 32'd1);

        // Reset while a core read is pending
        do_reset();
        core_set(1'b1, 1'b0, 16'h0010, 16'h0);
        step();
        check_eq("rstmid_gnt", 32'(obs_cg), 32'd1);
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        step();
        check_eq("rstmid_rvalid0", 32'(obs_crv), 32'd0);
        check_eq("rstmid_rdata0", 32'(obs_crd), 32'd0);
        step();
        check_eq("rstmid_rvalid1", 32'(obs_crv), 32'd0);
        rst = 1'b0;
        step();
        check_eq("rstmid_rvalid2", 32'(obs_crv), 32'd0);

        // Loader withdraws while losing
        do_reset();
        core_set(1'b1, 1'b0, 16'h0030, 16'h0);
        ldr_set(1'b1, 1'b0, 16'h0031, 16'h0);
        for (int i = 0; i < 2; i++) begin
            step();
`ifndef C16_DMEM_ARB_RR_EN
            check_eq("withdraw_ldr_gnt", 32'(obs_lg), 32'd0);
`endif
        end
`ifndef C16_DMEM_ARB_RR_EN
        check_eq("withdraw_cnt2", 32'(dut.starve_cnt), 32'd2);
`endif
        ldr_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();
`ifndef C16_DMEM_ARB_RR_EN
        check_eq("withdraw_ldr_gnt", 32'(obs_lg), 32'd0);
        check_eq("withdraw_cnt0", 32'(dut.starve_cnt), 32'd0);
`endif
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();

        // Random traffic honouring the hold-until-grant rule
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!(bus.core_req && !exp_cg_q) || $urandom_range(0, 7) == 0)
                core_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         16'($urandom_range(0, 255)), 16'($urandom));
            if (!(bus.ldr_req && !exp_lg_q) || $urandom_range(0, 7) == 0)
                ldr_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 255)), 16'($urandom));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        core_set(1'b0, 1'b0, 16'h0, 16'h0);
        ldr_set(1'b0, 1'b0, 16'h0, 16'h0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port (port B of the dual-port instruction/data RAM) between two requesters: the core's load/store path from the execute stage, and the debug/program loader driven from the board switches. Issues at most one access per cycle. Returns read data one cycle after grant, routed to the requester that issued the read. Raises a stall to the decode stage while a core request waits.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `STARVE_LIMIT`, 3, consecutive lost cycles before the loader is forced ahead of the core (legal range 1..15)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `core_req`, `core_we`  in  1  core access request / write select
- `core_addr`  in  AW  core address
- `core_wdata`  in  DW  core write data
- `core_gnt`  out  1  core access issued this cycle
- `core_rvalid`  out  1  core read data valid
- `core_rdata`  out  DW  core read data
- `core_stall`  out  1  `core_req & ~core_gnt`, feeds the decode-stage stall input
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`  as core, for the loader
- `mem_addr`  out  AW  RAM port B address
- `mem_wdata`  out  DW  RAM port B data
- `mem_wren`  out  1  RAM port B write enable
- `mem_rdata`  in  DW  RAM port B q (registered RAM, 1-cycle latency)

## Operation
- Grant is combinational from the current requests and the priority state. Exactly zero or one `*_gnt` is high.
- Requester rule: hold `req`, `we`, `addr`, `wdata` stable until the cycle its `gnt` is high. Dropping `req` before grant is legal and withdraws the request.
- Granted requester's `addr`, `wdata`, `we` drive `mem_*`. With no grant: `mem_addr` = 0, `mem_wdata` = 0, `mem_wren` = 0.
- Read grant (`we` = 0): registers `rd_pend` = 1 and `rd_owner` = requester ID. In the next cycle the owner's `rvalid` = 1 and its `rdata` = `mem_rdata`. The other requester's `rdata` reads 0.
- Write grant: no `rvalid`. A read and a write in consecutive cycles to the same address returns the old data (RAM read-before-write is not relied on; a bench must not require forwarding).
- Default policy is fixed priority, core first, with starvation escape:
  - `starve_cnt` increments each cycle `ldr_req & ~ldr_gnt`, saturating at `STARVE_LIMIT`.
  - While `starve_cnt == STARVE_LIMIT`, the loader beats the core.
  - `starve_cnt` clears on any `ldr_gnt` or when `ldr_req` drops.
- Back-to-back grants every cycle are allowed. A read-data return in cycle t+1 coexists with a new grant in t+1.

## Timing
- Reset values:
  - all `*_gnt`, `*_rvalid`, `mem_wren` = 0
  - `*_rdata` = 0
  - `rd_pend` = 0
  - `starve_cnt` = 0
  - `last_win` = LOADER
- Latency: request to grant is 0 cycles when uncontended; grant to `rvalid` is exactly 1 cycle.
- `rst` asserted while `rd_pend` = 1: the return is squashed, and no `rvalid` appears in the following cycle.
- `rst` has priority over every request in the same cycle: no grant, `mem_wren` = 0.
- Both requests in the same cycle with `starve_cnt < STARVE_LIMIT`: core wins and `core_stall` = 0; loader waits.

## Configuration
- `C16_DMEM_ARB_RR_EN` defined: round-robin policy.
  - On contention the requester other than `last_win` is granted.
  - `last_win` updates on every grant.
  - `starve_cnt` is not built; `STARVE_LIMIT` is ignored.
- Undefined: fixed priority with starvation escape, as described under Operation. `last_win` is not built.

## Structure
- `c16_pkg` holds:
  - `req_id_t` (`REQ_CORE` = 0, `REQ_LOADER` = 1)
  - the read-pending record (`valid`, `owner`)
  - default `AW`/`DW` constants, shared with the register file and fetch stages
- One sub-module, `dmem_pick`: purely combinational winner selection from `core_req`, `ldr_req`, `starve_cnt`/`last_win`. It is instantiated once. Counters, return routing and the `mem_*` mux stay in `dmem_arbiter`.

## Test plan
- Core-only read: `core_req`=1, `we`=0, `addr`=0x0010, RAM[0x10]=0xBEEF. Required: `core_gnt`=1 in the same cycle; next cycle `core_rvalid`=1, `core_rdata`=0xBEEF; `ldr_rvalid`=0.
- Contention: both request reads every cycle, `STARVE_LIMIT`=3, macro off. Required: core granted for 3 cycles, loader granted in the 4th, pattern repeats; `core_stall`=1 only in loader-grant cycles.
- Round-robin (macro on): both request continuously. Required: grants alternate starting with core after reset (C,L,C,L...); each `rvalid` goes to the matching owner one cycle later.
- Write then read: loader writes 0x1234 to 0x0020, then the core reads 0x0020 two cycles later. Required: `mem_wren`=1 for exactly one cycle; `core_rdata`=0x1234.
- Reset mid-read: core read granted, `rst`=1 in the next cycle. Required: `core_rvalid`=0 in both following cycles; all outputs at reset values.
- Withdrawn request: loader asserts `req` for 2 cycles while losing, then drops it. Required: `ldr_gnt` never asserts; `starve_cnt` returns to 0.
